// File: rtl/pio_edge_irq.sv
// pio_edge_irq: Avalon-MM PIO with one output register and synchronised, edge-captured inputs
// driving a maskable level interrupt; define PIO_DEBOUNCE_EN to build per-bit debounce counters.
module pio_edge_irq #(
   parameter int                   IN_WIDTH        = 8,
   parameter int                   OUT_WIDTH       = 8,
   parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0,
   parameter int                   EDGE_MODE       = 0,
   parameter int                   DEBOUNCE_CYCLES = 50000
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset,
   input  logic [1:0]           avs_address,
   input  logic                 avs_read,
   input  logic                 avs_write,
   input  logic [31:0]          avs_writedata,
   output logic [31:0]          avs_readdata,
   input  logic [IN_WIDTH-1:0]  in_export,
   output logic [OUT_WIDTH-1:0] out_export,
   output logic                 irq
);
   logic [IN_WIDTH-1:0]  r_sync1, r_sync2, r_stable, r_stable_q, r_mask, r_cap;
   logic [OUT_WIDTH-1:0] r_out;
   logic [31:0]          r_rdata;
   logic [IN_WIDTH-1:0]  w_rise, w_fall, w_evt, w_clr;
   logic [31:0]          w_rdata;
   logic                 w_unused;

   assign w_rise = r_stable & ~r_stable_q;
   assign w_fall = ~r_stable & r_stable_q;
   assign w_evt = EDGE_MODE == 0 ? w_rise : EDGE_MODE == 1 ? w_fall : w_rise | w_fall;
   assign w_clr = (avs_write && avs_address == 2'd3) ? avs_writedata[IN_WIDTH-1:0] : '0;
   assign w_rdata = avs_address == 2'd0 ? 32'(r_stable) :
                    avs_address == 2'd1 ? 32'(r_out) :
                    avs_address == 2'd2 ? 32'(r_mask) : 32'(r_cap);
   assign w_unused = &{1'b0, avs_writedata, 1'(DEBOUNCE_CYCLES)};
   assign irq = |(r_cap & r_mask);
   assign out_export = r_out;
   assign avs_readdata = r_rdata;

   always_ff @(posedge clk_clk or posedge reset_reset)
      if (reset_reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= in_export;
         r_sync2 <= r_sync1;
      end

`ifdef PIO_DEBOUNCE_EN
   localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
   logic [CW-1:0] r_cnt [IN_WIDTH];

   // a change is accepted only once it has differed from stable for CMAX counted cycles
   always_ff @(posedge clk_clk or posedge reset_reset)
      if (reset_reset) begin
         r_stable <= '0;
         for (int i = 0; i < IN_WIDTH; i++) r_cnt[i] <= '0;
      end else
         for (int i = 0; i < IN_WIDTH; i++)
            if (r_sync2[i] == r_stable[i]) r_cnt[i] <= '0;
            else if (r_cnt[i] == CMAX) begin
               r_stable[i] <= r_sync2[i];
               r_cnt[i] <= '0;
            end else r_cnt[i] <= r_cnt[i] + 1'b1;
`else
   always_ff @(posedge clk_clk or posedge reset_reset)
      if (reset_reset) r_stable <= '0;
      else r_stable <= r_sync2;
`endif

   // capture set dominates a simultaneous W1C of the same bit
   always_ff @(posedge clk_clk or posedge reset_reset)
      if (reset_reset) begin
         r_stable_q <= '0;
         r_cap <= '0;
         r_mask <= '0;
         r_out <= OUT_RESET;
         r_rdata <= '0;
      end else begin
         r_stable_q <= r_stable;
         r_cap <= (r_cap & ~w_clr) | w_evt;
         if (avs_write && avs_address == 2'd1) r_out <= avs_writedata[OUT_WIDTH-1:0];
         if (avs_write && avs_address == 2'd2) r_mask <= avs_writedata[IN_WIDTH-1:0];
         if (avs_read) r_rdata <= w_rdata;
      end
endmodule

// File: tb/tb_pio_edge_irq.sv
// tb_pio_edge_irq: three instances (rising / either / falling capture, the last one narrow) driven in
// lockstep, checked by a window-based reference model plus directed register and timing sequences.
module tb_pio_edge_irq;
   localparam int N  = 3;
   localparam int DC = 4;
`ifdef PIO_DEBOUNCE_EN
   localparam int L = DC + 3;
`else
   localparam int L = 3;
`endif
   typedef struct {
      logic        r;
      logic        w;
      logic [1:0]  a;
      logic [31:0] d;
      logic [7:0]  eo;
      logic [31:0] eq;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  addr = '0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [31:0] wd = '0;
   logic [7:0]  din = '0;
   logic [31:0] q0, q1, q2;
   logic [7:0]  o0, o1;
   logic [5:0]  o2;
   logic        i0, i1, i2;
   int          tests = 0;
   int          fails = 0;

   logic [31:0] m_out [N];
   logic [31:0] m_mask [N];
   logic [31:0] m_cap [N];
   logic [31:0] m_q [N];
   logic [7:0]  m_st, m_stq;
   logic [7:0]  hs [$];
   logic [7:0]  win [$];

   always #5 clk = ~clk;

   pio_edge_irq #(.IN_WIDTH(8), .OUT_WIDTH(8), .OUT_RESET(8'hA5), .EDGE_MODE(0), .DEBOUNCE_CYCLES(DC)) u0 (
      .clk_clk(clk), .reset_reset(rst), .avs_address(addr), .avs_read(rd), .avs_write(wr),
      .avs_writedata(wd), .avs_readdata(q0), .in_export(din), .out_export(o0), .irq(i0));
   pio_edge_irq #(.IN_WIDTH(8), .OUT_WIDTH(8), .OUT_RESET(8'h00), .EDGE_MODE(2), .DEBOUNCE_CYCLES(DC)) u1 (
      .clk_clk(clk), .reset_reset(rst), .avs_address(addr), .avs_read(rd), .avs_write(wr),
      .avs_writedata(wd), .avs_readdata(q1), .in_export(din), .out_export(o1), .irq(i1));
   pio_edge_irq #(.IN_WIDTH(5), .OUT_WIDTH(6), .OUT_RESET(6'h2A), .EDGE_MODE(1), .DEBOUNCE_CYCLES(DC)) u2 (
      .clk_clk(clk), .reset_reset(rst), .avs_address(addr), .avs_read(rd), .avs_write(wr),
      .avs_writedata(wd), .avs_readdata(q2), .in_export(din[4:0]), .out_export(o2), .irq(i2));

   function automatic logic [31:0] imsk(int n); return n == 2 ? 32'h1F : 32'hFF; endfunction
   function automatic logic [31:0] omsk(int n); return n == 2 ? 32'h3F : 32'hFF; endfunction
   function automatic logic [31:0] orst(int n); return n == 0 ? 32'hA5 : n == 1 ? 32'h00 : 32'h2A; endfunction
   function automatic int emode(int n); return n == 0 ? 0 : n == 1 ? 2 : 1; endfunction
   function automatic logic [31:0] d_q(int n); return n == 0 ? q0 : n == 1 ? q1 : q2; endfunction
   function automatic logic [31:0] d_out(int n); return n == 0 ? 32'(o0) : n == 1 ? 32'(o1) : 32'(o2); endfunction
   function automatic logic d_irq(int n); return n == 0 ? i0 : n == 1 ? i1 : i2; endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      hs.delete();
      win.delete();
      m_st = '0;
      m_stq = '0;
      for (int n = 0; n < N; n++) begin
         m_out[n] = orst(n);
         m_mask[n] = '0;
         m_cap[n] = '0;
         m_q[n] = '0;
      end
   endtask

   // One clock: predict from the rules, advance, then compare every instance.
   task automatic tick();
      logic [7:0]  s2, nst;
      logic [31:0] ev, clr, pre;
      logic [31:0] n_out [N];
      logic [31:0] n_mask [N];
      logic [31:0] n_cap [N];
      logic [31:0] n_q [N];
`ifdef PIO_DEBOUNCE_EN
      logic [7:0]  tw [$];
`endif
      s2 = hs.size() >= 2 ? hs[hs.size() - 2] : 8'h00;
`ifdef PIO_DEBOUNCE_EN
      tw = win;
      tw.push_back(s2);
      if (tw.size() > DC + 1) void'(tw.pop_front());
      nst = m_st;
      if (tw.size() == DC + 1)
         for (int b = 0; b < 8; b++) begin
            logic same;
            same = 1'b1;
            foreach (tw[k]) if (tw[k][b] != tw[0][b]) same = 1'b0;
            if (same && tw[0][b] != m_st[b]) nst[b] = tw[0][b];
         end
`else
      nst = s2;
`endif
      for (int n = 0; n < N; n++) begin
         ev = emode(n) == 0 ? 32'(m_st & ~m_stq) : emode(n) == 1 ? 32'(~m_st & m_stq) : 32'(m_st ^ m_stq);
         ev &= imsk(n);
         clr = (wr && addr == 2'd3) ? wd : 32'h0;
         pre = addr == 2'd0 ? (32'(m_st) & imsk(n)) : addr == 2'd1 ? m_out[n] : addr == 2'd2 ? m_mask[n] : m_cap[n];
         n_cap[n] = (m_cap[n] & ~clr) | ev;
         n_mask[n] = (wr && addr == 2'd2) ? (wd & imsk(n)) : m_mask[n];
         n_out[n] = (wr && addr == 2'd1) ? (wd & omsk(n)) : m_out[n];
         n_q[n] = rd ? pre : m_q[n];
      end
      @(posedge clk);
      if (!rst) begin
         m_out = n_out;
         m_mask = n_mask;
         m_cap = n_cap;
         m_q = n_q;
         m_stq = m_st;
         m_st = nst;
         hs.push_back(din);
         if (hs.size() > 4) void'(hs.pop_front());
`ifdef PIO_DEBOUNCE_EN
         win = tw;
`endif
      end
      #1;
      for (int n = 0; n < N; n++) begin
         chk($sformatf("u%0d out", n), d_out(n), m_out[n]);
         chk($sformatf("u%0d irq", n), 32'(d_irq(n)), 32'(|(m_cap[n] & m_mask[n])));
         chk($sformatf("u%0d rdata", n), d_q(n), m_q[n]);
      end
   endtask

   task automatic idle(input int k);
      for (int j = 0; j < k; j++) tick();
   endtask

   task automatic op(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d);
      rd = r;
      wr = w;
      addr = a;
      wd = d;
      tick();
      rd = 1'b0;
      wr = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rd = 1'b0;
      wr = 1'b0;
      model_reset();
      #1;
      chk("reset out", 32'(o0), 32'hA5);
      chk("reset irq", 32'(i0), 32'h0);
      chk("reset rdata", q0, 32'h0);
      tick();
      rst = 1'b0;
   endtask

   // counts clocks after the sampling clock until u0 raises irq
   task automatic measure(input string nm);
      int lat;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!i0 && lat < 30);
      chk(nm, lat, L);
   endtask

   initial begin
      vec_t tv [12];
      int   k;
      tv[0]  = '{1'b1, 1'b0, 2'd0, 32'h0,         8'hA5, 32'h00};
      tv[1]  = '{1'b1, 1'b0, 2'd1, 32'h0,         8'hA5, 32'hA5};
      tv[2]  = '{1'b1, 1'b0, 2'd2, 32'h0,         8'hA5, 32'h00};
      tv[3]  = '{1'b1, 1'b0, 2'd3, 32'h0,         8'hA5, 32'h00};
      tv[4]  = '{1'b0, 1'b1, 2'd1, 32'h0000_013C, 8'h3C, 32'h00};
      tv[5]  = '{1'b1, 1'b0, 2'd1, 32'h0,         8'h3C, 32'h3C};
      tv[6]  = '{1'b0, 1'b1, 2'd0, 32'hFF,        8'h3C, 32'h3C};
      tv[7]  = '{1'b1, 1'b0, 2'd0, 32'h0,         8'h3C, 32'h00};
      tv[8]  = '{1'b0, 1'b1, 2'd2, 32'hFFFF_FF01, 8'h3C, 32'h00};
      tv[9]  = '{1'b1, 1'b0, 2'd2, 32'h0,         8'h3C, 32'h01};
      tv[10] = '{1'b1, 1'b1, 2'd1, 32'h55,        8'h55, 32'h3C};
      tv[11] = '{1'b1, 1'b0, 2'd1, 32'h0,         8'h55, 32'h55};
      #2 do_reset();
      foreach (tv[j]) begin
         op(tv[j].r, tv[j].w, tv[j].a, tv[j].d);
         chk($sformatf("vec%0d out", j), 32'(o0), 32'(tv[j].eo));
         chk($sformatf("vec%0d rdata", j), q0, tv[j].eq);
         chk($sformatf("vec%0d irq", j), 32'(i0), 32'h0);
      end
`ifdef PIO_DEBOUNCE_EN
      din = 8'h01;
      idle(3);
      din = 8'h00;
      for (int j = 0; j < 12; j++) begin
         tick();
         chk("short pulse irq", 32'(i0), 32'h0);
      end
      op(1'b1, 1'b0, 2'd3, 32'h0);
      chk("short pulse cap", q0, 32'h0);
`else
      op(1'b0, 1'b1, 2'd2, 32'h05);
      din = 8'h04;
      tick();
      din = 8'h00;
      idle(2);
      chk("glitch irq lat2", 32'(i0), 32'h0);
      tick();
      chk("glitch irq lat3", 32'(i0), 32'h1);
      op(1'b1, 1'b0, 2'd3, 32'h0);
      chk("glitch cap", q0, 32'h04);
      op(1'b0, 1'b1, 2'd3, 32'hFF);
      idle(3);
      op(1'b0, 1'b1, 2'd3, 32'hFF);
      chk("glitch cleared", 32'(i0), 32'h0);
`endif
      din = 8'h01;
      tick();
      measure("hold latency");
      op(1'b0, 1'b1, 2'd3, 32'h1);
      chk("w1c irq drop", 32'(i0), 32'h0);
      op(1'b1, 1'b0, 2'd3, 32'h0);
      chk("w1c cap", q0, 32'h0);
      din = 8'h00;
      idle(L + 3);
      op(1'b0, 1'b1, 2'd3, 32'hFF);
      din = 8'h01;
      tick();
      idle(L - 1);
      op(1'b0, 1'b1, 2'd3, 32'h1);
      chk("set wins irq", 32'(i0), 32'h1);
      op(1'b1, 1'b0, 2'd3, 32'h0);
      chk("set wins cap", q0, 32'h01);
      din = 8'h00;
      idle(L + 3);
      din = 8'h02;
      idle(2);
      do_reset();
      op(1'b0, 1'b1, 2'd2, 32'h02);
      measure("requalify latency");
      do_reset();
      din = 8'h08;
      idle(L + 3);
      din = 8'h00;
      idle(L + 3);
      op(1'b1, 1'b0, 2'd3, 32'h0);
      chk("either cap", q1, 32'h08);
      chk("either irq masked", 32'(i1), 32'h0);
      chk("rise cap", q0, 32'h08);
      chk("fall cap", q2, 32'h08);
      op(1'b0, 1'b1, 2'd2, 32'h08);
      chk("either irq unmasked", 32'(i1), 32'h1);
      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(0, 149) == 0) do_reset();
         if ($urandom_range(0, 5) == 0) din ^= 8'(1 << $urandom_range(0, 7));
         k = int'($urandom_range(0, 9));
         rd = k < 3;
         wr = k >= 2 && k < 6;
         addr = 2'($urandom_range(0, 3));
         wd = $urandom;
         tick();
      end
      rd = 1'b0;
      wr = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
